// File: rtl/vga_win_pkg.sv
// vga_win_pkg: shared coordinate and window configuration types for the window detector
package vga_win_pkg;
    localparam int COORD_W    = 11;
    localparam int WIN_WIDTH  = 480;
    localparam int WIN_HEIGHT = 360;
    typedef logic [COORD_W-1:0] coord_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   en;
    } win_cfg_t;
endpackage

// File: rtl/window_hit.sv
// window_hit: combinational hit test and window-relative coordinates for one window
module window_hit
    import vga_win_pkg::*;
#(
    parameter int WIDTH  = WIN_WIDTH,
    parameter int HEIGHT = WIN_HEIGHT
) (
    input  logic [COORD_W-1:0] hc,
    input  logic [COORD_W-1:0] vc,
    input  win_cfg_t           cfg,
    output logic               hit,
    output logic [COORD_W-1:0] rel_x,
    output logic [COORD_W-1:0] rel_y
);
    // far edges carry one extra bit so windows near the counter limit clip instead of wrapping
    logic [COORD_W:0] x_end, y_end;
    assign x_end = {1'b0, cfg.x} + (COORD_W+1)'(WIDTH);
    assign y_end = {1'b0, cfg.y} + (COORD_W+1)'(HEIGHT);
    assign hit   = cfg.en && hc >= cfg.x && {1'b0, hc} < x_end && vc >= cfg.y && {1'b0, vc} < y_end;
    assign rel_x = hc - cfg.x;
    assign rel_y = vc - cfg.y;
endmodule

// File: rtl/vga_window_array.sv
// vga_window_array: N_WIN programmable windows with frame-origin double buffering and priority select
module vga_window_array
    import vga_win_pkg::*;
#(
    parameter int N_WIN  = 2,
    parameter int CW     = COORD_W,
    parameter int WIDTH  = WIN_WIDTH,
    parameter int HEIGHT = WIN_HEIGHT,
    parameter int IDW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    hc,
    input  logic [CW-1:0]    vc,
    input  logic             cfg_we,
    input  logic [IDW-1:0]   cfg_idx,
    input  logic [CW-1:0]    cfg_x,
    input  logic [CW-1:0]    cfg_y,
    input  logic             cfg_en,
    output logic             visible,
    output logic [IDW-1:0]   win_id,
    output logic [N_WIN-1:0] win_hits,
    output logic [CW-1:0]    rel_x,
    output logic [CW-1:0]    rel_y,
    output logic             commit
);
    win_cfg_t          pending [N_WIN];
    win_cfg_t          active  [N_WIN];
    logic [N_WIN-1:0]  hits;
    logic [CW-1:0]     rx [N_WIN];
    logic [CW-1:0]     ry [N_WIN];
    logic [IDW-1:0]    sel;
    logic [CW-1:0]     sel_x, sel_y;
    logic              origin;
    assign origin = hc == '0 && vc == '0;
    for (genvar g = 0; g < N_WIN; g++) begin : g_win
        window_hit #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hit (
            .hc(hc), .vc(vc), .cfg(active[g]),
            .hit(hits[g]), .rel_x(rx[g]), .rel_y(ry[g])
        );
    end
    // descending scan so the lowest hitting index is the last assignment
    always_comb begin
        sel   = '0;
        sel_x = '0;
        sel_y = '0;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (hits[i]) begin
                sel   = IDW'(i);
                sel_x = rx[i];
                sel_y = ry[i];
            end
        end
    end
    // a write landing on the origin cycle misses this commit because active samples the old pending
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_WIN; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
            visible  <= 1'b0;
            win_id   <= '0;
            win_hits <= '0;
            rel_x    <= '0;
            rel_y    <= '0;
            commit   <= 1'b0;
        end else begin
            for (int i = 0; i < N_WIN; i++) begin
                if (cfg_we && cfg_idx == IDW'(i)) pending[i] <= '{x: cfg_x, y: cfg_y, en: cfg_en};
                if (origin) active[i] <= pending[i];
            end
            visible  <= |hits;
            win_id   <= sel;
            win_hits <= hits;
            rel_x    <= sel_x;
            rel_y    <= sel_y;
            commit   <= origin;
        end
    end
endmodule

// File: tb/tb_vga_window_array.sv
// tb_vga_window_array: directed and random scan checks against an integer window model
module tb_vga_window_array;
    localparam int N = 2;
    logic        clk = 0, rst = 0;
    logic [10:0] hc = 0, vc = 0, cfg_x = 0, cfg_y = 0;
    logic        cfg_we = 0, cfg_en = 0;
    logic [2:0]  cfg_idx = 0;
    logic        visible, commit;
    logic [2:0]  win_id;
    logic [1:0]  win_hits;
    logic [10:0] rel_x, rel_y;
    int checks = 0, passed = 0;
    int px [N], py [N], pe [N], ax [N], ay [N], ae [N];
    int e_vis, e_id, e_hits, e_rx, e_ry, e_com;

    vga_window_array dut (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .visible(visible), .win_id(win_id),
        .win_hits(win_hits), .rel_x(rel_x), .rel_y(rel_y), .commit(commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d at hc=%0d vc=%0d", tag, obs, exp, hc, vc);
    endtask

    // model: a pixel is inside when it lies in [x, x+480) x [y, y+360); integers never wrap
    task automatic step(input int h, input int v, input bit r = 0, input bit we = 0,
                        input int idx = 0, input int x = 0, input int y = 0, input bit en = 0);
        hc = 11'(h); vc = 11'(v); rst = r; cfg_we = we; cfg_idx = 3'(idx);
        cfg_x = 11'(x); cfg_y = 11'(y); cfg_en = en;
        e_vis = 0; e_id = 0; e_hits = 0; e_rx = 0; e_ry = 0;
        for (int i = 0; i < N; i++)
            if (ae[i] != 0 && h >= ax[i] && h < ax[i] + 480 && v >= ay[i] && v < ay[i] + 360) begin
                e_hits |= 1 << i;
                if (!e_vis) begin e_vis = 1; e_id = i; e_rx = h - ax[i]; e_ry = v - ay[i]; end
            end
        e_com = (h == 0 && v == 0) ? 1 : 0;
        if (r) begin
            e_vis = 0; e_id = 0; e_hits = 0; e_rx = 0; e_ry = 0; e_com = 0;
            for (int i = 0; i < N; i++) begin px[i] = 0; py[i] = 0; pe[i] = 0; ax[i] = 0; ay[i] = 0; ae[i] = 0; end
        end else begin
            if (h == 0 && v == 0) begin ax = px; ay = py; ae = pe; end
            if (we && idx < N) begin px[idx] = x; py[idx] = y; pe[idx] = en; end
        end
        @(posedge clk);
        #1;
        cfg_we = 0;
        chk("visible", int'(visible), e_vis);
        chk("win_id", int'(win_id), e_id);
        chk("win_hits", int'(win_hits), e_hits);
        chk("rel_x", int'(rel_x), e_rx);
        chk("rel_y", int'(rel_y), e_ry);
        chk("commit", int'(commit), e_com);
    endtask

    initial begin
        step(5, 5, 1);
        step(5, 5, 1);
        chk("reset_visible", int'(visible), 0);
        // idle scan: nothing enabled, commit only at the origin
        for (int v = 0; v < 3; v++) for (int h = 0; h < 800; h += 7) step(h, v);
        step(0, 0);
        chk("idle_commit", int'(commit), 1);
        step(799, 524);
        // single window
        step(10, 10, 0, 1, 0, 100, 50, 1);
        step(0, 0);
        chk("commit_pulse", int'(commit), 1);
        step(100, 50);
        chk("origin_hit", int'(visible), 1);
        chk("origin_rel", int'(rel_x), 0);
        step(579, 50);
        chk("right_edge", int'(rel_x), 479);
        step(580, 50);
        chk("past_right", int'(visible), 0);
        step(99, 50);
        chk("left_of", int'(visible), 0);
        step(100, 409);
        step(100, 410);
        // overlap
        step(20, 20, 0, 1, 1, 300, 100, 1);
        step(0, 0);
        step(350, 150);
        chk("ovl_hits", int'(win_hits), 3);
        chk("ovl_relx", int'(rel_x), 250);
        step(30, 30, 0, 1, 0, 100, 50, 0);
        step(350, 150);
        chk("pre_commit_id", int'(win_id), 0);
        step(0, 0);
        step(350, 150);
        chk("dis_hits", int'(win_hits), 2);
        chk("dis_id", int'(win_id), 1);
        chk("dis_rely", int'(rel_y), 50);
        // collision: write on the origin cycle waits one frame
        step(40, 40, 0, 1, 0, 100, 50, 1);
        step(0, 0, 0, 1, 0, 200, 50, 1);
        step(150, 60);
        chk("coll_old", int'(win_id), 0);
        step(0, 0);
        step(150, 60);
        chk("coll_new", int'(win_hits), 0);
        step(200, 60);
        // wrap guard
        step(50, 50, 0, 1, 1, 2000, 0, 1);
        step(0, 0);
        for (int h = 2000; h < 2048; h++) step(h, 0);
        for (int h = 1; h < 432; h += 3) step(h, 0);
        step(2047, 359);
        step(2047, 360);
        // mid-frame reset while visible
        step(400, 200);
        chk("pre_reset_vis", int'(visible), 1);
        step(400, 200, 1);
        chk("reset_vis", int'(visible), 0);
        step(0, 0);
        step(400, 200);
        chk("post_reset_vis", int'(visible), 0);
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            int h, v;
            h = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(0, 2047);
            v = (h == 0 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 2047);
            if ($urandom_range(0, 3) != 0) begin h = h % 800; v = v % 525; end
            step(h, v, $urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 3 ? $urandom_range(0, 7) : $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0 ? $urandom_range(1500, 2047) : $urandom_range(0, 700),
                 $urandom_range(0, 3) == 0 ? $urandom_range(1500, 2047) : $urandom_range(0, 400),
                 $urandom_range(0, 4) != 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/vga_window_array.md
Name: vga_window_array

Overview:
- Multi-window region detector for the VGA display path.
- Driven by the shared hc/vc pixel counters.
- Holds N_WIN independently positioned, runtime-programmable rectangular windows.
- Emits a registered visible flag, the winning window index, per-window hit vector and window-relative pixel coordinates for the serial-display sprite/text renderers.
- Position updates are double-buffered and committed only at frame origin, so no tearing occurs mid-frame.

Parameters:
- N_WIN, 2, number of windows (1..8).
- CW, 11, counter and coordinate width in bits.
- WIDTH, 480, window width in pixels; identical for all windows.
- HEIGHT, 360, window height in pixels; identical for all windows.
- IDW, 3, width of window index fields; must satisfy 2**IDW >= N_WIN.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hc  in  CW  horizontal pixel counter
- vc  in  CW  vertical pixel counter
- cfg_we  in  1  config write strobe, single-cycle
- cfg_idx  in  IDW  window being written
- cfg_x  in  CW  window left edge
- cfg_y  in  CW  window top edge
- cfg_en  in  1  window enable
- visible  out  1  any enabled window hit (registered)
- win_id  out  IDW  lowest-index hitting window; 0 when visible=0
- win_hits  out  N_WIN  per-window hit bits
- rel_x  out  CW  hc - x of winning window; 0 when visible=0
- rel_y  out  CW  vc - y of winning window; 0 when visible=0
- commit  out  1  pulses on the cycle after active registers were loaded

Behaviour:
- Reset (synchronous, active-high, clk): all pending and active x/y/en cleared; all outputs 0.
- Config path:
  - On cfg_we=1 with cfg_idx < N_WIN: pending[cfg_idx] <= {cfg_x, cfg_y, cfg_en}.
  - cfg_idx >= N_WIN: write ignored.
  - Back-to-back writes to the same index: last one wins.
- Commit:
  - Commit condition: hc==0 && vc==0.
  - On that cycle active[i] <= pending[i] for all i.
  - commit=1 on the following cycle, otherwise 0.
- Commit/write collision: if a cfg write and the commit condition occur in the same cycle, the commit loads the pre-write pending value; the new write takes effect at the next frame origin.
- Hit test for window i, combinational, on active registers:
  - hit_i = en_i && hc >= x_i && hc < x_i+WIDTH && vc >= y_i && vc < y_i+HEIGHT.
  - Edges are inclusive at the origin and exclusive at the far edge.
  - Sums x_i+WIDTH and y_i+HEIGHT are computed in CW+1 bits, so a window near the counter maximum does not wrap. It is clipped: hits only where hc/vc can reach.
- Priority: lowest index among set hit bits wins.
- Relative coordinates: computed from the winner's x/y, CW bits.
- Latency:
  - All outputs are registered, 1 clk after hc/vc.
  - The frame-origin pixel (0,0) is tested against the already-loaded active registers only if the commit happened earlier. The commit cycle itself uses the old active values, and new positions apply from pixel (1,0) onward.
- Disabled window: never hits, regardless of position.
- Overlap: win_hits shows all overlapping windows; win_id/rel_x/rel_y follow the lowest index only.
- No state machine beyond the pending/active register banks and the commit pulse flop.

Decomposition:
- Package vga_win_pkg holds:
  - typedef coord_t (logic [CW-1:0]);
  - struct win_cfg_t {coord_t x; coord_t y; logic en;};
  - default constants WIN_WIDTH=480, WIN_HEIGHT=360.
- Sub-module window_hit, instantiated N_WIN times:
  - inputs hc, vc, win_cfg_t;
  - outputs hit, rel_x, rel_y;
  - purely combinational, with the CW+1-bit edge arithmetic.
- Top level owns the register banks, commit logic, priority encoder and output registers.

Test Plan:
- Reset, then sweep hc=0..799, vc=0..524 with no writes -> visible, win_hits, commit remain 0 except a commit pulse at each frame origin; active registers all 0.
- Write win0 x=100 y=50 en=1, then frame origin -> commit pulse at the cycle after (0,0).
  - hc=100, vc=50 -> one clk later visible=1, win_id=0, rel_x=0, rel_y=0.
  - hc=579 -> visible=1, rel_x=479.
  - hc=580 -> visible=0.
  - hc=99 -> visible=0.
- Overlap: win0 x=100 y=50 and win1 x=300 y=100, both enabled; hc=350, vc=150 -> win_hits=2'b11, win_id=0, rel_x=250, rel_y=100.
  - Disable win0 via cfg_en=0 -> after next frame origin, same pixel gives win_hits=2'b10, win_id=1, rel_x=50, rel_y=50.
- Collision: cfg_we for win0 x=200 issued on the exact cycle hc=0, vc=0 -> current frame still uses old x=100; the following frame uses x=200.
- Wrap guard: win1 x=2000 y=0 en=1 (CW=11) -> hit at hc=2000..2047 with rel_x=0..47; no false hit at hc=0..431.
- Mid-frame reset at hc=400, vc=200 while visible=1 -> visible=0 on the next clk; stays 0 until new writes and a commit.
